// File: rtl/select_pkg.sv
// Shared types and board-level timing constants for the select debouncer.
package select_pkg;

   typedef enum logic [1:0] {S_LOW, S_RISE, S_HIGH, S_FALL} db_state_t;

   localparam int unsigned CLK_HZ      = 12_000_000;
   localparam int unsigned DEBOUNCE_MS = 10;
   localparam int unsigned REPEAT_MS   = 500;

   function automatic int unsigned ms_to_cycles(input int unsigned ms);
      return CLK_HZ / 1000 * ms;
   endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchroniser bringing an asynchronous level into the clk domain.
module sync_2ff (
   input  logic clk,
   input  logic rst,
   input  logic d,
   output logic q
);

   logic meta;

   // NOTE: non-blocking assignments make meta and q a true two-stage shift
   // register; blocking here would collapse it into a single flop.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         meta <= 1'b0;
         q    <= 1'b0;
      end else begin
         meta <= d;
         q    <= meta;
      end
   end

endmodule

// File: rtl/select_debouncer.sv
// Debounces a raw button and toggles a registered mux select on each press.
// Define HOLD_REPEAT_EN to auto-repeat the toggle while the button is held.
module select_debouncer
   import select_pkg::*;
#(
   parameter int unsigned STABLE_CYCLES = ms_to_cycles(DEBOUNCE_MS),
   parameter logic        SEL_RESET     = 1'b0,
   parameter int unsigned REPEAT_CYCLES = ms_to_cycles(REPEAT_MS)
) (
   input  logic clk,
   input  logic rst,
   input  logic btn_in,
   output logic btn_level,
   output logic press_pulse,
   output logic sel_out
);

   localparam int unsigned     CW       = $clog2(STABLE_CYCLES + 1);
   localparam logic [CW-1:0]   CNT_LAST = CW'(STABLE_CYCLES - 1);
   localparam logic [CW-1:0]   CNT_ONE  = CW'(1);

   if (STABLE_CYCLES < 2) begin : g_bad_stable
      $error("select_debouncer: STABLE_CYCLES must be at least 2");
   end
   if (REPEAT_CYCLES < 2) begin : g_bad_repeat
      $error("select_debouncer: REPEAT_CYCLES must be at least 2");
   end

   logic          btn_s;
   db_state_t     state, state_nxt;
   logic [CW-1:0] cnt, cnt_nxt;
   logic          level_nxt, pulse_nxt, sel_nxt;

   sync_2ff u_sync (
      .clk (clk),
      .rst (rst),
      .d   (btn_in),
      .q   (btn_s)
   );

`ifdef HOLD_REPEAT_EN
   localparam int unsigned   RW       = $clog2(REPEAT_CYCLES + 1);
   localparam logic [RW-1:0] REP_LAST = RW'(REPEAT_CYCLES - 1);

   logic [RW-1:0] rep_cnt, rep_nxt;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) rep_cnt <= '0;
      else     rep_cnt <= rep_nxt;
   end
`endif

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state       <= S_LOW;
         cnt         <= '0;
         btn_level   <= 1'b0;
         press_pulse <= 1'b0;
         sel_out     <= SEL_RESET;
      end else begin
         state       <= state_nxt;
         cnt         <= cnt_nxt;
         btn_level   <= level_nxt;
         press_pulse <= pulse_nxt;
         sel_out     <= sel_nxt;
      end
   end

   // NOTE: every output of this block gets a default first, so no path
   // through the case can leave a signal unassigned and infer a latch.
   always_comb begin
      state_nxt = state;
      cnt_nxt   = cnt;
      level_nxt = btn_level;
      pulse_nxt = 1'b0;
      sel_nxt   = sel_out;
`ifdef HOLD_REPEAT_EN
      rep_nxt   = rep_cnt;
`endif
      case (state)
         S_LOW: begin
            if (btn_s) begin
               state_nxt = S_RISE;
               cnt_nxt   = CNT_ONE;
            end else begin
               cnt_nxt   = '0;
            end
         end
         S_RISE: begin
            if (!btn_s) begin
               state_nxt = S_LOW;
               cnt_nxt   = '0;
            end else if (cnt == CNT_LAST) begin
               state_nxt = S_HIGH;
               cnt_nxt   = '0;
               level_nxt = 1'b1;
               pulse_nxt = 1'b1;
               sel_nxt   = ~sel_out;
`ifdef HOLD_REPEAT_EN
               rep_nxt   = '0;
`endif
            end else begin
               cnt_nxt   = cnt + CNT_ONE;
            end
         end
         S_HIGH: begin
            if (!btn_s) begin
               state_nxt = S_FALL;
               cnt_nxt   = CNT_ONE;
`ifdef HOLD_REPEAT_EN
               rep_nxt   = '0;
`endif
            end else begin
               cnt_nxt   = '0;
`ifdef HOLD_REPEAT_EN
               if (rep_cnt == REP_LAST) begin
                  pulse_nxt = 1'b1;
                  sel_nxt   = ~sel_out;
                  rep_nxt   = '0;
               end else begin
                  rep_nxt   = rep_cnt + RW'(1);
               end
`endif
            end
         end
         S_FALL: begin
            // A bounce back to high re-enters S_HIGH and restarts any repeat interval.
            if (btn_s) begin
               state_nxt = S_HIGH;
               cnt_nxt   = '0;
`ifdef HOLD_REPEAT_EN
               rep_nxt   = '0;
`endif
            end else if (cnt == CNT_LAST) begin
               state_nxt = S_LOW;
               cnt_nxt   = '0;
               level_nxt = 1'b0;
            end else begin
               cnt_nxt   = cnt + CNT_ONE;
            end
         end
         default: begin
            state_nxt = S_LOW;
            cnt_nxt   = '0;
         end
      endcase
   end

endmodule
